fm_wb_collector: RTL and testbench

Write-back collector downstream of the PE-matrix per-row feature-map/guard generators. It accepts one 8-bit output word stream and one 6-bit guard stream per PE row through valid/ready handshakes, buffers each in a 2-entry FIFO, and round-robin arbitrates them onto a single feature-map buffer write port and a single guard buffer write port. Write addresses are generated per row from a configured base and stride. A done pulse is issued when every row has delivered its configured count.

---
 rtl/diff_core_pkg.sv | 13 +
 rtl/wb_fifo2.sv | 54 +++++
 rtl/fm_wb_collector.sv | 221 ++++++++++++++++++++++
 tb/tb_fm_wb_collector.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/diff_core_pkg.sv
// Definitions shared across the diffusion core: PE geometry and the
// write-back collector state encoding.
package diff_core_pkg;

  localparam int CONF_PE_ROW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry FIFO holding one row's words ahead of the write-port arbiter.
// Head and flags come straight from registers, so ready logic sees a stable full flag.
module wb_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_r [2];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       cnt_r;
  logic             push_s;
  logic             pop_s;

  assign push_s = push && (cnt_r != 2'd2);
  assign pop_s  = pop && (cnt_r != 2'd0);
  assign dout   = mem_r[rd_ptr_r];
  assign empty  = (cnt_r == 2'd0);
  assign full   = (cnt_r == 2'd2);

  // storage, pointers and occupancy; simultaneous push and pop both take effect
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      cnt_r    <= 2'd0;
    end else if (clr) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      cnt_r    <= 2'd0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      cnt_r <= cnt_r + {1'b0, push_s} - {1'b0, pop_s};
    end
  end

endmodule

// File: rtl/fm_wb_collector.sv
// Write-back collector: buffers per-row word and guard streams and round-robins
// them onto single feature-map and guard buffer write ports with per-row addressing.
module fm_wb_collector
  import diff_core_pkg::*;
#(
  parameter int NUM_ROW    = CONF_PE_ROW,
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_WIDTH  = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid_i,
  output logic                    cfg_ready_o,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [ADDR_WIDTH-1:0]   row_stride_i,
  input  logic [CNT_WIDTH-1:0]    word_num_i,
  input  logic [CNT_WIDTH-1:0]    guard_num_i,
  input  logic [NUM_ROW-1:0][7:0] wb_data_i,
  input  logic [NUM_ROW-1:0]      wb_valid_i,
  output logic [NUM_ROW-1:0]      wb_ready_o,
  input  logic [NUM_ROW-1:0][5:0] guard_i,
  input  logic [NUM_ROW-1:0]      guard_valid_i,
  output logic [NUM_ROW-1:0]      guard_ready_o,
  output logic                    fm_wr_en_o,
  output logic [ADDR_WIDTH-1:0]   fm_wr_addr_o,
  output logic [7:0]              fm_wr_data_o,
  input  logic                    fm_wr_ready_i,
  output logic                    guard_wr_en_o,
  output logic [ADDR_WIDTH-1:0]   guard_wr_addr_o,
  output logic [5:0]              guard_wr_data_o,
  input  logic                    guard_wr_ready_i,
  output logic                    done_o
);

  localparam int RW = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1;

  wb_state_t             state_r, state_s;
  logic [ADDR_WIDTH-1:0] row_base_r [NUM_ROW];
  logic [CNT_WIDTH-1:0]  word_num_r, guard_num_r;
  logic [CNT_WIDTH-1:0]  fm_acc_r [NUM_ROW];
  logic [CNT_WIDTH-1:0]  gd_acc_r [NUM_ROW];
  logic [CNT_WIDTH-1:0]  fm_cnt_r [NUM_ROW];
  logic [CNT_WIDTH-1:0]  gd_cnt_r [NUM_ROW];
  logic [7:0]            fm_head_s [NUM_ROW];
  logic [5:0]            gd_head_s [NUM_ROW];
  logic [NUM_ROW-1:0]    fm_empty_s, fm_full_s, fm_push_s, fm_pop_s;
  logic [NUM_ROW-1:0]    gd_empty_s, gd_full_s, gd_push_s, gd_pop_s;
  logic                  run_s, cfg_fire_s, all_done_s;
  logic [RW-1:0]         fm_ptr_r, fm_hold_r, fm_gnt_s;
  logic [RW-1:0]         gd_ptr_r, gd_hold_r, gd_gnt_s;
  logic [RW:0]           fm_pick_s, gd_pick_s;
  logic                  fm_lock_r, fm_any_s, fm_fire_s;
  logic                  gd_lock_r, gd_any_s, gd_fire_s;

  // First requester at or after ptr; MSB flags that any row requested.
  function automatic logic [RW:0] rr_pick(input logic [NUM_ROW-1:0] req,
                                          input logic [RW-1:0] ptr);
    logic [RW:0] res;
    int          idx;
    res = '0;
    for (int i = NUM_ROW - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_ROW;
      if (req[idx]) res = {1'b1, RW'(idx)};
      else          res = res;
    end
    return res;
  endfunction

  function automatic logic [RW-1:0] next_ptr(input logic [RW-1:0] g);
    return (g == RW'(NUM_ROW - 1)) ? '0 : g + RW'(1);
  endfunction

  for (genvar r = 0; r < NUM_ROW; r++) begin : g_row
    wb_fifo2 #(.WIDTH(8)) u_fm_fifo (
      .clk(clk), .rst(rst), .clr(cfg_fire_s), .push(fm_push_s[r]), .din(wb_data_i[r]),
      .pop(fm_pop_s[r]), .dout(fm_head_s[r]), .empty(fm_empty_s[r]), .full(fm_full_s[r])
    );
    wb_fifo2 #(.WIDTH(6)) u_gd_fifo (
      .clk(clk), .rst(rst), .clr(cfg_fire_s), .push(gd_push_s[r]), .din(guard_i[r]),
      .pop(gd_pop_s[r]), .dout(gd_head_s[r]), .empty(gd_empty_s[r]), .full(gd_full_s[r])
    );
  end

  assign run_s       = (state_r == RUN);
  assign cfg_ready_o = (state_r == IDLE);
  assign done_o      = (state_r == DONE);
  assign fm_push_s   = wb_valid_i & wb_ready_o;
  assign gd_push_s   = guard_valid_i & guard_ready_o;

  // per-row input ready (count includes words still in the FIFO) and layer drain detect
  always_comb begin
    all_done_s = (&fm_empty_s) && (&gd_empty_s);
    for (int r = 0; r < NUM_ROW; r++) begin
      wb_ready_o[r]    = run_s && !fm_full_s[r] && (fm_acc_r[r] < word_num_r);
      guard_ready_o[r] = run_s && !gd_full_s[r] && (gd_acc_r[r] < guard_num_r);
      if ((fm_cnt_r[r] != word_num_r) || (gd_cnt_r[r] != guard_num_r)) all_done_s = 1'b0;
      else                                                               all_done_s = all_done_s;
    end
  end

  // next-state logic
  always_comb begin
    state_s    = state_r;
    cfg_fire_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (cfg_valid_i) begin
          state_s    = RUN;
          cfg_fire_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (all_done_s) state_s = DONE;
        else            state_s = RUN;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // feature-map port: a stalled grant is locked so later rows cannot pre-empt it
  always_comb begin
    fm_pick_s = rr_pick(~fm_empty_s, fm_ptr_r);
    fm_pop_s  = '0;
    if (fm_lock_r) begin
      fm_gnt_s = fm_hold_r;
      fm_any_s = 1'b1;
    end else begin
      fm_gnt_s = fm_pick_s[RW-1:0];
      fm_any_s = fm_pick_s[RW];
    end
    fm_wr_en_o = fm_any_s && run_s && !rst;
    fm_fire_s  = fm_wr_en_o && fm_wr_ready_i;
    if (fm_fire_s) fm_pop_s[fm_gnt_s] = 1'b1;
    else           fm_pop_s = '0;
    if (fm_wr_en_o) begin
      fm_wr_addr_o = row_base_r[fm_gnt_s] + ADDR_WIDTH'(fm_cnt_r[fm_gnt_s]);
      fm_wr_data_o = fm_head_s[fm_gnt_s];
    end else begin
      fm_wr_addr_o = '0;
      fm_wr_data_o = 8'd0;
    end
  end

  // guard port: independent copy of the feature-map arbiter
  always_comb begin
    gd_pick_s = rr_pick(~gd_empty_s, gd_ptr_r);
    gd_pop_s  = '0;
    if (gd_lock_r) begin
      gd_gnt_s = gd_hold_r;
      gd_any_s = 1'b1;
    end else begin
      gd_gnt_s = gd_pick_s[RW-1:0];
      gd_any_s = gd_pick_s[RW];
    end
    guard_wr_en_o = gd_any_s && run_s && !rst;
    gd_fire_s     = guard_wr_en_o && guard_wr_ready_i;
    if (gd_fire_s) gd_pop_s[gd_gnt_s] = 1'b1;
    else           gd_pop_s = '0;
    if (guard_wr_en_o) begin
      guard_wr_addr_o = row_base_r[gd_gnt_s] + ADDR_WIDTH'(gd_cnt_r[gd_gnt_s]);
      guard_wr_data_o = gd_head_s[gd_gnt_s];
    end else begin
      guard_wr_addr_o = '0;
      guard_wr_data_o = 6'd0;
    end
  end

  // state, configuration, per-row counters and arbiter pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      word_num_r  <= '0;
      guard_num_r <= '0;
      fm_ptr_r    <= '0;
      gd_ptr_r    <= '0;
      fm_hold_r   <= '0;
      gd_hold_r   <= '0;
      fm_lock_r   <= 1'b0;
      gd_lock_r   <= 1'b0;
      for (int r = 0; r < NUM_ROW; r++) begin
        row_base_r[r] <= '0;
        fm_acc_r[r]   <= '0;
        gd_acc_r[r]   <= '0;
        fm_cnt_r[r]   <= '0;
        gd_cnt_r[r]   <= '0;
      end
    end else begin
      state_r   <= state_s;
      fm_lock_r <= fm_wr_en_o && !fm_wr_ready_i;
      gd_lock_r <= guard_wr_en_o && !guard_wr_ready_i;
      fm_hold_r <= fm_gnt_s;
      gd_hold_r <= gd_gnt_s;
      if (cfg_fire_s) begin
        word_num_r  <= word_num_i;
        guard_num_r <= guard_num_i;
        fm_ptr_r    <= '0;
        gd_ptr_r    <= '0;
        for (int r = 0; r < NUM_ROW; r++) begin
          row_base_r[r] <= base_addr_i + ADDR_WIDTH'(r) * row_stride_i;
          fm_acc_r[r]   <= '0;
          gd_acc_r[r]   <= '0;
          fm_cnt_r[r]   <= '0;
          gd_cnt_r[r]   <= '0;
        end
      end else begin
        if (fm_fire_s) fm_ptr_r <= next_ptr(fm_gnt_s);
        if (gd_fire_s) gd_ptr_r <= next_ptr(gd_gnt_s);
        for (int r = 0; r < NUM_ROW; r++) begin
          if (fm_push_s[r]) fm_acc_r[r] <= fm_acc_r[r] + CNT_WIDTH'(1);
          if (gd_push_s[r]) gd_acc_r[r] <= gd_acc_r[r] + CNT_WIDTH'(1);
          if (fm_pop_s[r])  fm_cnt_r[r] <= fm_cnt_r[r] + CNT_WIDTH'(1);
          if (gd_pop_s[r])  gd_cnt_r[r] <= gd_cnt_r[r] + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fm_wb_collector.sv
// Directed bench for fm_wb_collector: per-row sources, a write-port log and
// hand-derived expected write sequences.
module tb_fm_wb_collector;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_valid_i;
  logic            cfg_ready_o;
  logic [11:0]     base_addr_i, row_stride_i;
  logic [9:0]      word_num_i, guard_num_i;
  logic [3:0][7:0] wb_data_i;
  logic [3:0]      wb_valid_i, wb_ready_o;
  logic [3:0][5:0] guard_i;
  logic [3:0]      guard_valid_i, guard_ready_o;
  logic            fm_wr_en_o, fm_wr_ready_i;
  logic [11:0]     fm_wr_addr_o;
  logic [7:0]      fm_wr_data_o;
  logic            guard_wr_en_o, guard_wr_ready_i;
  logic [11:0]     guard_wr_addr_o;
  logic [5:0]      guard_wr_data_o;
  logic            done_o;

  always #5 clk = ~clk;

  fm_wb_collector dut (
    .clk(clk), .rst(rst), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .base_addr_i(base_addr_i), .row_stride_i(row_stride_i),
    .word_num_i(word_num_i), .guard_num_i(guard_num_i),
    .wb_data_i(wb_data_i), .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o),
    .guard_i(guard_i), .guard_valid_i(guard_valid_i), .guard_ready_o(guard_ready_o),
    .fm_wr_en_o(fm_wr_en_o), .fm_wr_addr_o(fm_wr_addr_o), .fm_wr_data_o(fm_wr_data_o),
    .fm_wr_ready_i(fm_wr_ready_i),
    .guard_wr_en_o(guard_wr_en_o), .guard_wr_addr_o(guard_wr_addr_o),
    .guard_wr_data_o(guard_wr_data_o), .guard_wr_ready_i(guard_wr_ready_i),
    .done_o(done_o)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int done_cnt = 0;
  logic [3:0] en_w, en_g;
  int lim_w [4];
  int lim_g [4];
  int sent_w [4];
  int sent_g [4];
  logic [11:0] fm_addr_q [$];
  logic [7:0]  fm_data_q [$];
  logic [11:0] gd_addr_q [$];
  logic [5:0]  gd_data_q [$];
  logic [11:0] exp_fm_addr [$];
  logic [7:0]  exp_fm_data [$];
  logic [11:0] exp_gd_addr [$];
  logic [5:0]  exp_gd_data [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Source words carry row*16+index, guards row*8+index.
  task automatic drive_src();
    for (int r = 0; r < 4; r++) begin
      wb_valid_i[r]    = en_w[r] && (sent_w[r] < lim_w[r]);
      wb_data_i[r]     = 8'(r * 16 + sent_w[r]);
      guard_valid_i[r] = en_g[r] && (sent_g[r] < lim_g[r]);
      guard_i[r]       = 6'(r * 8 + sent_g[r]);
    end
  endtask

  // Record handshakes and writes at negedge, then advance to 1 time unit after posedge.
  task automatic cycle();
    @(negedge clk);
    for (int r = 0; r < 4; r++) begin
      if (wb_valid_i[r] && wb_ready_o[r]) sent_w[r]++;
      if (guard_valid_i[r] && guard_ready_o[r]) sent_g[r]++;
    end
    if (fm_wr_en_o && fm_wr_ready_i) begin
      fm_addr_q.push_back(fm_wr_addr_o);
      fm_data_q.push_back(fm_wr_data_o);
    end
    if (guard_wr_en_o && guard_wr_ready_i) begin
      gd_addr_q.push_back(guard_wr_addr_o);
      gd_data_q.push_back(guard_wr_data_o);
    end
    if (done_o) done_cnt++;
    @(posedge clk);
    #1;
    drive_src();
  endtask

  task automatic start_test(input int lw, input int lg);
    for (int r = 0; r < 4; r++) begin
      sent_w[r] = 0; sent_g[r] = 0; lim_w[r] = lw; lim_g[r] = lg;
    end
    en_w = 4'h0; en_g = 4'h0; done_cnt = 0;
    fm_addr_q.delete(); fm_data_q.delete(); gd_addr_q.delete(); gd_data_q.delete();
    exp_fm_addr.delete(); exp_fm_data.delete(); exp_gd_addr.delete(); exp_gd_data.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; en_w = 4'h0; en_g = 4'h0; cfg_valid_i = 1'b0;
    wb_valid_i = 4'h0; guard_valid_i = 4'h0;
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  task automatic configure(input logic [11:0] b, input logic [11:0] s,
                           input logic [9:0] wn, input logic [9:0] gn);
    base_addr_i = b; row_stride_i = s; word_num_i = wn; guard_num_i = gn;
    cfg_valid_i = 1'b1;
    cycle();
    cfg_valid_i = 1'b0;
  endtask

  task automatic add_fm(input int a, input int d);
    exp_fm_addr.push_back(12'(a));
    exp_fm_data.push_back(8'(d));
  endtask

  task automatic add_gd(input int a, input int d);
    exp_gd_addr.push_back(12'(a));
    exp_gd_data.push_back(6'(d));
  endtask

  // All four rows streaming from the same cycle: strict r0..r3 order each round.
  task automatic exp_all_rows(input int b, input int s, input int wn, input int gn);
    for (int k = 0; k < wn; k++)
      for (int r = 0; r < 4; r++) add_fm(b + r * s + k, r * 16 + k);
    for (int k = 0; k < gn; k++)
      for (int r = 0; r < 4; r++) add_gd(b + r * s + k, r * 8 + k);
  endtask

  task automatic compare_logs(input string tag);
    int n;
    check_eq($sformatf("%s_fm_count", tag), fm_addr_q.size(), exp_fm_addr.size());
    n = (fm_addr_q.size() < exp_fm_addr.size()) ? fm_addr_q.size() : exp_fm_addr.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_fm%0d_addr", tag, i), fm_addr_q[i], exp_fm_addr[i]);
      check_eq($sformatf("%s_fm%0d_data", tag, i), fm_data_q[i], exp_fm_data[i]);
    end
    check_eq($sformatf("%s_gd_count", tag), gd_addr_q.size(), exp_gd_addr.size());
    n = (gd_addr_q.size() < exp_gd_addr.size()) ? gd_addr_q.size() : exp_gd_addr.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_gd%0d_addr", tag, i), gd_addr_q[i], exp_gd_addr[i]);
      check_eq($sformatf("%s_gd%0d_data", tag, i), gd_data_q[i], exp_gd_data[i]);
    end
  endtask

  task automatic run_until_done(input string tag, input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) cycle();
    repeat (6) cycle();
    check_eq($sformatf("%s_done_pulses", tag), done_cnt, 1);
    #2;
    check_eq($sformatf("%s_cfg_ready_after", tag), cfg_ready_o, 1'b1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_cfg_ready"}, cfg_ready_o, 1'b1);
    check_eq({tag, "_wb_ready"}, wb_ready_o, 4'h0);
    check_eq({tag, "_guard_ready"}, guard_ready_o, 4'h0);
    check_eq({tag, "_fm_en"}, fm_wr_en_o, 1'b0);
    check_eq({tag, "_fm_addr"}, fm_wr_addr_o, 12'h000);
    check_eq({tag, "_fm_data"}, fm_wr_data_o, 8'h00);
    check_eq({tag, "_gd_en"}, guard_wr_en_o, 1'b0);
    check_eq({tag, "_gd_addr"}, guard_wr_addr_o, 12'h000);
    check_eq({tag, "_gd_data"}, guard_wr_data_o, 6'h00);
    check_eq({tag, "_done"}, done_o, 1'b0);
  endtask

  initial begin
    int rows [3];
    rows = '{3, 0, 1};
    rst = 1'b1; cfg_valid_i = 1'b0; base_addr_i = 12'h000; row_stride_i = 12'h000;
    word_num_i = 10'd0; guard_num_i = 10'd0; wb_data_i = '0; wb_valid_i = 4'h0;
    guard_i = '0; guard_valid_i = 4'h0; fm_wr_ready_i = 1'b1; guard_wr_ready_i = 1'b1;
    start_test(0, 0);
    do_reset();
    #2;
    check_idle_outputs("reset");

    // basic: all rows stream continuously
    start_test(3, 1);
    en_w = 4'hF; en_g = 4'hF;
    configure(12'h100, 12'h040, 10'd3, 10'd1);
    #2;
    check_eq("basic_first_ready", wb_ready_o, 4'hF);
    check_eq("basic_first_gready", guard_ready_o, 4'hF);
    check_eq("basic_cfg_ready_run", cfg_ready_o, 1'b0);
    run_until_done("basic", 100);
    exp_all_rows(32'h100, 32'h40, 3, 1);
    compare_logs("basic");

    // stall: feature-map port blocked for five cycles from the first write
    start_test(4, 1);
    en_w = 4'hF; en_g = 4'hF;
    fm_wr_ready_i = 1'b0;
    configure(12'h200, 12'h010, 10'd4, 10'd1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      #2;
      check_eq($sformatf("stall%0d_en", i), fm_wr_en_o, 1'b1);
      check_eq($sformatf("stall%0d_addr", i), fm_wr_addr_o, 12'h200);
      check_eq($sformatf("stall%0d_data", i), fm_wr_data_o, 8'h00);
    end
    check_eq("stall_ready_drop", wb_ready_o, 4'h0);
    cycle();
    fm_wr_ready_i = 1'b1;
    run_until_done("stall", 100);
    exp_all_rows(32'h200, 32'h10, 4, 1);
    compare_logs("stall");
    for (int r = 0; r < 4; r++) check_eq($sformatf("stall_sent_r%0d", r), sent_w[r], 4);

    // skewed rows with over-delivery on row 2; a cfg request mid-run is ignored
    start_test(5, 1);
    lim_w[2] = 8;
    en_w = 4'b0100; en_g = 4'b0100;
    configure(12'h300, 12'h020, 10'd5, 10'd1);
    cycle();
    base_addr_i = 12'h000; cfg_valid_i = 1'b1;
    #2;
    check_eq("skew_cfg_ready_busy", cfg_ready_o, 1'b0);
    cycle();
    cfg_valid_i = 1'b0;
    repeat (8) cycle();
    #2;
    check_eq("skew_r2_ready_low", wb_ready_o[2], 1'b0);
    check_eq("skew_r2_writes", fm_addr_q.size(), 5);
    check_eq("skew_r2_sent", sent_w[2], 5);
    en_w = 4'hF; en_g = 4'hF;
    run_until_done("skew", 100);
    check_eq("skew_r2_sent_end", sent_w[2], 5);
    for (int k = 0; k < 5; k++) add_fm(32'h340 + k, 32'h20 + k);
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < 3; j++) add_fm(32'h300 + rows[j] * 32'h20 + k, rows[j] * 16 + k);
    add_gd(32'h340, 32'h10);
    for (int j = 0; j < 3; j++) add_gd(32'h300 + rows[j] * 32'h20, rows[j] * 8);
    compare_logs("skew");

    // address wrap: one row active, stride 0
    start_test(4, 1);
    en_w = 4'b0010; en_g = 4'b0010;
    configure(12'hFFE, 12'h000, 10'd4, 10'd1);
    repeat (12) cycle();
    #2;
    check_eq("wrap_no_done", done_cnt, 0);
    check_eq("wrap_r1_ready_low", wb_ready_o[1], 1'b0);
    for (int k = 0; k < 4; k++) add_fm(32'hFFE + k, 32'h10 + k);
    add_gd(32'hFFE, 32'h08);
    compare_logs("wrap");
    do_reset();

    // reset in the middle of a layer
    start_test(3, 1);
    en_w = 4'hF; en_g = 4'hF;
    configure(12'h100, 12'h040, 10'd3, 10'd1);
    for (int i = 0; i < 40 && fm_addr_q.size() < 5; i++) cycle();
    check_eq("mid_rst_five_writes", fm_addr_q.size() >= 5, 1'b1);
    rst = 1'b1; en_w = 4'h0; en_g = 4'h0;
    #2;
    check_eq("mid_rst_cycle_fm_en", fm_wr_en_o, 1'b0);
    check_eq("mid_rst_cycle_gd_en", guard_wr_en_o, 1'b0);
    cycle();
    rst = 1'b0;
    #2;
    check_idle_outputs("mid_rst");
    cycle();
    #2;
    check_eq("mid_rst_next_fm_en", fm_wr_en_o, 1'b0);

    // fresh configuration after the reset restarts every count from zero
    start_test(3, 1);
    en_w = 4'hF; en_g = 4'hF;
    configure(12'h100, 12'h040, 10'd3, 10'd1);
    run_until_done("restart", 100);
    exp_all_rows(32'h100, 32'h40, 3, 1);
    compare_logs("restart");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
